// File: rtl/a4_filt_pkg.sv
// Shared types and defaults for the filtered AND-gate qualifier macros.
// The state encoding keeps the filtered level in bit 1, so q is a plain wire off the state register.
package a4_filt_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    PEND_HI = 2'b01,
    IDLE_HI = 2'b11,
    PEND_LO = 2'b10
  } a4_filt_state_t;

  localparam int A4F_SYNC_DEF = 2;
  localparam int A4F_FILT_DEF = 4;

endpackage

// File: rtl/a4_sync_chain.sv
// Multi-flop synchronizer for one asynchronous bit; latency DEPTH edges, no flow control.
// Async active-low reset clears every stage to 0.
module a4_sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic ck,
  input  logic nrst,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_chain;

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/a4_sync_filter.sv
// Synchronizes the 4-input AND of async qualifiers and debounces it over FILT_CYCLES edges.
// A held change reaches q after SYNC_STAGES+FILT_CYCLES edges; no backpressure, en=0 aborts qualification.
module a4_sync_filter
  import a4_filt_pkg::*;
#(
  parameter int SYNC_STAGES = A4F_SYNC_DEF,
  parameter int FILT_CYCLES = A4F_FILT_DEF
) (
  input  logic ck,
  input  logic nrst,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic en,
  output logic q,
  output logic q_rise,
  output logic q_fall,
  output logic pend
);

  localparam int             CNT_W    = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic           w_raw;
  logic           w_s;
  a4_filt_state_t r_state;
  a4_filt_state_t w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic           r_rise;
  logic           r_fall;
  logic           r_pend;
  logic           w_rise_nxt;
  logic           w_fall_nxt;

  // Only the combined AND crosses the domain; the individual inputs never touch a flop.
  assign w_raw = i0 & i1 & i2 & i3;

  a4_sync_chain #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .ck   (ck),
    .nrst (nrst),
    .i_d  (w_raw),
    .o_q  (w_s)
  );

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE_LO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!en) begin
      // A disabled filter drops any partial qualification and falls back to the current level.
      w_cnt_nxt = '0;
      if (r_state == PEND_HI) w_state_nxt = IDLE_LO;
      if (r_state == PEND_LO) w_state_nxt = IDLE_HI;
    end else begin
      case (r_state)
        IDLE_LO: begin
          if (w_s) begin
            if (FILT_CYCLES == 1) begin
              w_state_nxt = IDLE_HI;
            end else begin
              w_state_nxt = PEND_HI;
              w_cnt_nxt   = CNT_ONE;
            end
          end
        end
        PEND_HI: begin
          if (!w_s) begin
            w_state_nxt = IDLE_LO;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = IDLE_HI;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!w_s) begin
            if (FILT_CYCLES == 1) begin
              w_state_nxt = IDLE_LO;
            end else begin
              w_state_nxt = PEND_LO;
              w_cnt_nxt   = CNT_ONE;
            end
          end
        end
        PEND_LO: begin
          if (w_s) begin
            w_state_nxt = IDLE_HI;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = IDLE_LO;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = IDLE_LO;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_rise_nxt = w_state_nxt[1] & ~r_state[1];
    w_fall_nxt = ~w_state_nxt[1] & r_state[1];
  end

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
      r_pend <= (w_cnt_nxt != '0);
    end
  end

  assign q      = r_state[1];
  assign q_rise = r_rise;
  assign q_fall = r_fall;
  assign pend   = r_pend;

endmodule

// File: tb/tb_a4_sync_filter.sv
// Scoreboard bench: each driven cycle queues the expected {q,q_rise,q_fall,pend}, popped after the edge.
// A second instance with FILT_CYCLES=1 and SYNC_STAGES=3 is checked through the reset/rise sequence.
module tb_a4_sync_filter;

  logic ck = 1'b0;
  logic nrst;
  logic i0, i1, i2, i3;
  logic en;
  logic q, q_rise, q_fall, pend;
  logic q1, q_rise1, q_fall1, pend1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [3:0] v;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb1_q[$];

  a4_sync_filter dut (
    .ck     (ck),
    .nrst   (nrst),
    .i0     (i0),
    .i1     (i1),
    .i2     (i2),
    .i3     (i3),
    .en     (en),
    .q      (q),
    .q_rise (q_rise),
    .q_fall (q_fall),
    .pend   (pend)
  );

  a4_sync_filter #(
    .SYNC_STAGES (3),
    .FILT_CYCLES (1)
  ) dut1 (
    .ck     (ck),
    .nrst   (nrst),
    .i0     (i0),
    .i1     (i1),
    .i2     (i2),
    .i3     (i3),
    .en     (en),
    .q      (q1),
    .q_rise (q_rise1),
    .q_fall (q_fall1),
    .pend   (pend1)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s q/rise/fall/pend obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic a, input logic b, input logic c, input logic d);
    i0 = a;
    i1 = b;
    i2 = c;
    i3 = d;
  endtask

  // Queue the expectation for the coming edge, then compare once the DUT has updated.
  task automatic step(input string tag, input logic [3:0] e,
                      input logic [3:0] e1 = 4'b0000, input bit use1 = 1'b0);
    exp_t x;
    x.tag = tag;
    x.v   = e;
    sb_q.push_back(x);
    if (use1) begin
      x.tag = {tag, "_f1"};
      x.v   = e1;
      sb1_q.push_back(x);
    end
    @(posedge ck);
    #1;
    x = sb_q.pop_front();
    chk(x.tag, {q, q_rise, q_fall, pend}, x.v);
    if (sb1_q.size() > 0) begin
      x = sb1_q.pop_front();
      chk(x.tag, {q1, q_rise1, q_fall1, pend1}, x.v);
    end
  endtask

  task automatic run(input string tag, input int n, input logic [3:0] e);
    for (int k = 0; k < n; k++) begin
      step($sformatf("%s_%0d", tag, k), e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    en   = 1'b1;
    set_in(1, 1, 1, 1);

    // Reset holds everything low even with raw=1, then a full-latency rise.
    for (int k = 0; k < 3; k++) step($sformatf("rst_%0d", k), 4'b0000, 4'b0000, 1'b1);
    nrst = 1'b1;
    step("rise_e1", 4'b0000, 4'b0000, 1'b1);
    step("rise_e2", 4'b0000, 4'b0000, 1'b1);
    step("rise_e3", 4'b0001, 4'b0000, 1'b1);
    step("rise_e4", 4'b0001, 4'b1100, 1'b1);
    step("rise_e5", 4'b0001, 4'b1000, 1'b1);
    step("rise_e6", 4'b1100);
    run("rise_hold", 2, 4'b1000);

    // Fall from q=1.
    set_in(0, 1, 1, 1);
    run("fall_e1", 2, 4'b1000);
    run("fall_e3", 3, 4'b1001);
    step("fall_e6", 4'b0010);
    run("fall_hold", 2, 4'b0000);

    // Three-cycle glitch never qualifies.
    set_in(1, 1, 1, 1);
    run("glitch_e1", 2, 4'b0000);
    step("glitch_e3", 4'b0001);
    set_in(1, 1, 0, 1);
    run("glitch_e4", 2, 4'b0001);
    run("glitch_e6", 3, 4'b0000);

    // Partial AND, then an unknown input masked by a zero.
    set_in(1, 1, 1, 0);
    run("partial", 50, 4'b0000);
    set_in(1, 0, 1, 1'bx);
    run("xmask", 10, 4'b0000);

    // Enable drop at cnt=2 restarts qualification from zero.
    set_in(1, 1, 1, 1);
    run("en_e1", 2, 4'b0000);
    run("en_e3", 2, 4'b0001);
    en = 1'b0;
    run("en_off", 3, 4'b0000);
    en = 1'b1;
    run("en_back", 3, 4'b0001);
    step("en_rise", 4'b1100);
    step("en_hold", 4'b1000);

    // With en=0 a settled low raw cannot move q.
    en = 1'b0;
    set_in(0, 1, 1, 1);
    run("en_holdq", 6, 4'b1000);
    en = 1'b1;
    run("en_fall_p", 3, 4'b1001);
    step("en_fall", 4'b0010);
    step("en_fall_hold", 4'b0000);

    // Async reset between edges while pending at cnt=3.
    set_in(1, 1, 1, 1);
    run("arst_pre_e1", 2, 4'b0000);
    run("arst_pre_e3", 3, 4'b0001);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_imm", {q, q_rise, q_fall, pend}, 4'b0000);
    #1;
    nrst = 1'b1;
    run("arst_e1", 2, 4'b0000);
    run("arst_e3", 3, 4'b0001);
    step("arst_rise", 4'b1100);
    step("arst_hold", 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
